// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM states and
// the result-width derivation.
package alu_pkg;

  // Operation select codes, sampled with start
  localparam logic [2:0] FUNC_ADD   = 3'b000;
  localparam logic [2:0] FUNC_ORXOR = 3'b001;
  localparam logic [2:0] FUNC_ANY   = 3'b010;
  localparam logic [2:0] FUNC_ALL   = 3'b011;
  localparam logic [2:0] FUNC_INV   = 3'b100;
  localparam logic [2:0] FUNC_SHL   = 3'b101;
  localparam logic [2:0] FUNC_MUL   = 3'b110;
  localparam logic [2:0] FUNC_NOP   = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Result width is twice the operand width
  function automatic int unsigned rw_of(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_alu_acc_if.sv
// Handshake/operand bundle between the switch/key front end and the ALU.
//   start, func, a, b, use_acc : request side (master drives)
//   result, busy, done         : response side (slave drives)
interface seq_alu_acc_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned RW = rw_of(WIDTH);

  logic             start;
  logic [2:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             use_acc;
  logic [RW-1:0]    result;
  logic             busy;
  logic             done;

  modport master (
    output start, func, a, b, use_acc,
    input  result, busy, done
  );

  modport slave (
    input  start, func, a, b, use_acc,
    output result, busy, done
  );

endinterface

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-add multiplier, one partial-product step per cycle.
//   clock, reset : clock and synchronous active-high reset
//   load         : capture a (multiplicand) and b (multiplier), start stepping
//   a, b         : WIDTH-bit operands
//   busy         : high for exactly WIDTH cycles after load
//   valid        : high in the final step cycle (combinational)
//   product      : partial sum including the current step (combinational);
//                  equals a*b while valid is high
module shift_add_mult #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [RW-1:0]    mcand_q,   mcand_d;
  logic [RW-1:0]    partial_q, partial_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             busy_q,    busy_d;
  logic [RW-1:0]    step_sum_c;
  logic             last_c;

  // Current step result and last-step detect
  always_comb begin
    step_sum_c = partial_q + (mplier_q[0] ? mcand_q : '0);
    last_c     = busy_q && (count_q == CW'(WIDTH - 1));
  end

  // Next-state for the datapath
  always_comb begin
    mcand_d   = mcand_q;
    partial_d = partial_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    busy_d    = busy_q;
    if (load) begin
      mcand_d   = RW'(a);
      mplier_d  = b;
      partial_d = '0;
      count_d   = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      partial_d = step_sum_c;
      mcand_d   = mcand_q << 1;
      mplier_d  = mplier_q >> 1;
      count_d   = count_q + CW'(1);
      if (last_c) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q   <= '0;
      partial_q <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      partial_q <= partial_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign valid   = last_c;
  assign product = step_sum_c;

endmodule

// File: rtl/seq_alu_acc.sv
// Registered ALU with accumulator feedback and a multi-cycle multiplier.
//   clock, reset : clock and synchronous active-high reset
//   io (slave)   : start/func/a/b/use_acc request; result/busy/done response.
//                  Single-cycle ops update result at the start edge; multiply
//                  holds result and raises busy for WIDTH cycles.
module seq_alu_acc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  seq_alu_acc_if.slave io
);

  localparam int unsigned RW = rw_of(WIDTH);
  localparam logic [RW-1:0] ANY_PAT = {1'b1, {(RW-2){1'b0}}, 1'b1};
  localparam logic [RW-1:0] ALL_PAT = ~ANY_PAT;

  state_e           state_q, state_d;
  logic [RW-1:0]    result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH:0]   sum_c;
  logic [RW-1:0]    alu_c;
  logic             mult_load_c;
  logic             mult_busy;
  logic             mult_valid;
  logic [RW-1:0]    mult_product;

  // Single-cycle operation results; B comes from the low half of result in accumulator mode
  always_comb begin
    b_eff_c = io.use_acc ? result_q[WIDTH-1:0] : io.b;
    sum_c   = (WIDTH+1)'(io.a) + (WIDTH+1)'(b_eff_c);
    alu_c   = result_q;
    case (io.func)
      FUNC_ADD:   alu_c = RW'(sum_c);
      FUNC_ORXOR: alu_c = {io.a ^ b_eff_c, io.a | b_eff_c};
      FUNC_ANY:   alu_c = ((|io.a) || (|b_eff_c)) ? ANY_PAT : '0;
      FUNC_ALL:   alu_c = ((&io.a) && (&b_eff_c)) ? ALL_PAT : '0;
      FUNC_INV:   alu_c = {~io.a, b_eff_c};
      FUNC_SHL:   alu_c = (32'(io.a) >= RW) ? '0 : (RW'(b_eff_c) << io.a);
      default:    alu_c = result_q;
    endcase
  end

  // Control FSM: IDLE accepts starts, MUL waits for the multiplier's last step
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    done_d      = 1'b0;
    mult_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          if (io.func == FUNC_MUL) begin
            state_d     = ST_MUL;
            mult_load_c = 1'b1;
          end else begin
            result_d = alu_c;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mult_valid) begin
          result_d = mult_product;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (!mult_busy) begin
          // Multiplier lost its run without finishing; recover to IDLE
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_MUL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  shift_add_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clock  (clock),
    .reset  (reset),
    .load   (mult_load_c),
    .a      (io.a),
    .b      (b_eff_c),
    .busy   (mult_busy),
    .valid  (mult_valid),
    .product(mult_product)
  );

  assign io.result = result_q;
  assign io.busy   = busy_q;
  assign io.done   = done_q;

endmodule
